// File: rtl/mult_stage_if.sv
// Issue-side and CDB-side handshake bundle for the pipelined RV32M multiply unit.
interface mult_stage_if #(
   parameter int XLEN     = 32,
   parameter int TAG_BITS = 6
);
   logic                in_valid;
   logic                in_ready;
   logic [1:0]          in_func;
   logic [XLEN-1:0]     in_rs1;
   logic [XLEN-1:0]     in_rs2;
   logic [TAG_BITS-1:0] in_dest_tag;
   logic                out_valid;
   logic                out_ready;
   logic [XLEN-1:0]     out_result;
   logic [TAG_BITS-1:0] out_dest_tag;
   logic [3:0]          busy_count;

   // master: issue stage plus CDB arbiter; slave: the multiply unit
   modport master (
      output in_valid, in_func, in_rs1, in_rs2, in_dest_tag, out_ready,
      input  in_ready, out_valid, out_result, out_dest_tag, busy_count
   );

   modport slave (
      input  in_valid, in_func, in_rs1, in_rs2, in_dest_tag, out_ready,
      output in_ready, out_valid, out_result, out_dest_tag, busy_count
   );
endinterface

// File: rtl/mult_stage.sv
// Pipelined RV32M multiplier: one slice of B per stage, A pre-shifted as it travels,
// whole-pipe stall on CDB back-pressure and a synchronous flush of every valid bit.
module mult_stage #(
   parameter int NUM_STAGES = 4,
   parameter int XLEN       = 32,
   parameter int TAG_BITS   = 6
) (
   input logic        clock,
   input logic        reset,
   input logic        flush,
   mult_stage_if.slave bus
);
   localparam int PW = 2 * XLEN;
   localparam int W  = PW / NUM_STAGES;
   localparam logic [1:0] F_MUL   = 2'd0;
   localparam logic [1:0] F_MULHU = 2'd3;

   logic [NUM_STAGES-1:0] r_vld;
   logic [PW-1:0]         r_a    [NUM_STAGES];
   logic [PW-1:0]         r_b    [NUM_STAGES];
   logic [PW-1:0]         r_acc  [NUM_STAGES];
   logic [1:0]            r_func [NUM_STAGES];
   logic [TAG_BITS-1:0]   r_tag  [NUM_STAGES];
   logic [3:0]            r_busy;

   logic                  w_stall;
   logic [NUM_STAGES-1:0] w_src_vld;
   logic [NUM_STAGES-1:0] w_vld_nxt;
   logic [PW-1:0]         w_src_a    [NUM_STAGES];
   logic [PW-1:0]         w_src_b    [NUM_STAGES];
   logic [PW-1:0]         w_src_acc  [NUM_STAGES];
   logic [1:0]            w_src_func [NUM_STAGES];
   logic [TAG_BITS-1:0]   w_src_tag  [NUM_STAGES];
   logic [PW-1:0]         w_pp       [NUM_STAGES];

   function automatic logic [PW-1:0] f_ext(input logic [XLEN-1:0] v, input logic sgn);
      return sgn ? {{XLEN{v[XLEN-1]}}, v} : {{XLEN{1'b0}}, v};
   endfunction

   function automatic logic [XLEN-1:0] f_select(input logic [PW-1:0] p, input logic [1:0] fn);
      return (fn == F_MUL) ? p[XLEN-1:0] : p[PW-1:XLEN];
   endfunction

   function automatic logic [3:0] f_popcount(input logic [NUM_STAGES-1:0] v);
      logic [3:0] cnt;
      cnt = '0;
      for (int i = 0; i < NUM_STAGES; i++) cnt = cnt + 4'(v[i]);
      return cnt;
   endfunction

   assign w_stall = r_vld[NUM_STAGES-1] & ~bus.out_ready;

   always_comb begin
      // stage 0 sources come straight from the issue packet, with operand extension
      w_src_vld[0]  = bus.in_valid & ~w_stall;
      w_src_a[0]    = f_ext(bus.in_rs1, bus.in_func != F_MULHU);
      w_src_b[0]    = f_ext(bus.in_rs2, ~bus.in_func[1]);
      w_src_acc[0]  = '0;
      w_src_func[0] = bus.in_func;
      w_src_tag[0]  = bus.in_dest_tag;
      for (int k = 1; k < NUM_STAGES; k++) begin
         w_src_vld[k]  = r_vld[k-1];
         w_src_a[k]    = r_a[k-1];
         w_src_b[k]    = r_b[k-1];
         w_src_acc[k]  = r_acc[k-1];
         w_src_func[k] = r_func[k-1];
         w_src_tag[k]  = r_tag[k-1];
      end
      // A arrives already shifted by k*W, so each partial product needs no extra shift
      for (int k = 0; k < NUM_STAGES; k++) begin
         w_pp[k]      = w_src_a[k] * PW'(w_src_b[k][W-1:0]);
         w_vld_nxt[k] = ~flush & (w_stall ? r_vld[k] : w_src_vld[k]);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_vld  <= '0;
         r_busy <= '0;
         for (int k = 0; k < NUM_STAGES; k++) begin
            r_a[k]    <= '0;
            r_b[k]    <= '0;
            r_acc[k]  <= '0;
            r_func[k] <= '0;
            r_tag[k]  <= '0;
         end
      end else begin
         r_vld  <= w_vld_nxt;
         r_busy <= f_popcount(w_vld_nxt);
         if (!w_stall) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
               r_a[k]    <= w_src_a[k] << W;
               r_b[k]    <= w_src_b[k] >> W;
               r_acc[k]  <= w_src_acc[k] + w_pp[k];
               r_func[k] <= w_src_func[k];
               r_tag[k]  <= w_src_tag[k];
            end
         end
      end
   end

   // result select sits after the last stage register, so no in_* to out_* path exists
   assign bus.in_ready     = ~w_stall;
   assign bus.out_valid    = r_vld[NUM_STAGES-1];
   assign bus.out_result   = f_select(r_acc[NUM_STAGES-1], r_func[NUM_STAGES-1]);
   assign bus.out_dest_tag = r_tag[NUM_STAGES-1];
   assign bus.busy_count   = r_busy;
endmodule

// File: tb/tb_mult_stage.sv
// Bench for mult_stage: directed scenarios plus a random regression against a
// result-level reference pipe fed by plain 64-bit products.
module tb_mult_stage;
   localparam int NS = 4;

   typedef struct packed {
      logic        vld;
      logic [31:0] res;
      logic [5:0]  tag;
   } ent_t;

   logic clock;
   logic reset;
   logic flush;

   mult_stage_if #(.XLEN(32), .TAG_BITS(6)) bus ();

   mult_stage #(.NUM_STAGES(NS), .XLEN(32), .TAG_BITS(6)) dut (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   int n_vec  = 0;
   int n_fail = 0;

   ent_t m_pipe [NS];
   logic m_stall;
   ent_t ck_e;
   int   ck_busy;

   logic        lit_en   = 1'b0;
   logic        lit_vld  = 1'b0;
   logic        lit_data = 1'b0;
   logic [31:0] lit_res  = '0;
   logic [5:0]  lit_tag  = '0;
   logic [3:0]  lit_busy = '0;
   logic        lit_rdy  = 1'b0;
   logic        gen_en   = 1'b0;
   int          gen_act  = 0;
   int          gen_exp  = 0;
   int          acc_cnt  = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] p;
      case (f)
         2'd0, 2'd1: p = longint'($signed(a)) * longint'($signed(b));
         2'd2:       p = longint'($signed(a)) * longint'({32'd0, b});
         default:    p = {32'd0, a} * {32'd0, b};
      endcase
      return (f == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   // Reference: results move through NS slots; whole pipe holds when the tail is stuck.
   initial begin
      for (int i = 0; i < NS; i++) m_pipe[i] = '0;
      forever begin
         @(posedge clock or negedge reset);
         if (!reset) begin
            for (int i = 0; i < NS; i++) m_pipe[i].vld = 1'b0;
         end else begin
            m_stall = m_pipe[NS-1].vld && !bus.out_ready;
            if (!m_stall) begin
               for (int i = NS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
               m_pipe[0].vld = bus.in_valid;
               m_pipe[0].res = ref_mul(bus.in_func, bus.in_rs1, bus.in_rs2);
               m_pipe[0].tag = bus.in_dest_tag;
            end
            if (flush) for (int i = 0; i < NS; i++) m_pipe[i].vld = 1'b0;
         end
      end
   end

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clock);
         ck_e    = m_pipe[NS-1];
         ck_busy = 0;
         for (int i = 0; i < NS; i++) ck_busy += int'(m_pipe[i].vld);
         cmp("out_valid", 64'(bus.out_valid), 64'(ck_e.vld));
         cmp("busy_count", 64'(bus.busy_count), 64'(ck_busy));
         cmp("in_ready", 64'(bus.in_ready), 64'(!(ck_e.vld && !bus.out_ready)));
         if (ck_e.vld) begin
            cmp("out_result", 64'(bus.out_result), 64'(ck_e.res));
            cmp("out_dest_tag", 64'(bus.out_dest_tag), 64'(ck_e.tag));
         end
         if (lit_en) begin
            cmp("lit_out_valid", 64'(bus.out_valid), 64'(lit_vld));
            cmp("lit_busy_count", 64'(bus.busy_count), 64'(lit_busy));
            cmp("lit_in_ready", 64'(bus.in_ready), 64'(lit_rdy));
            if (lit_data) begin
               cmp("lit_out_result", 64'(bus.out_result), 64'(lit_res));
               cmp("lit_out_dest_tag", 64'(bus.out_dest_tag), 64'(lit_tag));
               if (lit_vld) cmp("model_result", 64'(ck_e.res), 64'(lit_res));
            end
         end
         if (gen_en) cmp("random_ops_accepted", 64'(gen_act), 64'(gen_exp));
      end
   end

   task automatic expect_out(input logic v, input logic d, input logic [31:0] r,
                             input logic [5:0] t, input logic [3:0] b, input logic y);
      lit_vld  = v;
      lit_data = d;
      lit_res  = r;
      lit_tag  = t;
      lit_busy = b;
      lit_rdy  = y;
      lit_en   = 1'b1;
      @(negedge clock);
      #1 lit_en = 1'b0;
   endtask

   task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] t);
      bus.in_valid    = 1'b1;
      bus.in_func     = f;
      bus.in_rs1      = a;
      bus.in_rs2      = b;
      bus.in_dest_tag = t;
      @(posedge clock);
      #1 bus.in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_func = 2'd0;
      bus.in_rs1 = '0;
      bus.in_rs2 = '0;
      bus.in_dest_tag = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1 expect_out(1'b0, 1'b1, 32'h0, 6'd0, 4'd0, 1'b1);
      @(posedge clock);
      #1 reset = 1'b1;

      issue(2'd0, 32'd7, 32'hFFFF_FFFD, 6'd32);
      repeat (3) @(posedge clock);
      #1 expect_out(1'b1, 1'b1, 32'hFFFF_FFEB, 6'd32, 4'd1, 1'b1);

      issue(2'd1, 32'h8000_0000, 32'h8000_0000, 6'd33);
      issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd34);
      issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd35);
      @(posedge clock);
      #1 expect_out(1'b1, 1'b1, 32'h4000_0000, 6'd33, 4'd3, 1'b1);
      expect_out(1'b1, 1'b1, 32'hFFFF_FFFE, 6'd34, 4'd2, 1'b1);
      expect_out(1'b1, 1'b1, 32'hFFFF_FFFF, 6'd35, 4'd1, 1'b1);

      @(posedge clock);
      #1 bus.out_ready = 1'b0;
      issue(2'd3, 32'hFFFF_FFFF, 32'd2, 6'd40);
      issue(2'd0, 32'd1000, 32'hFFFF_FFFE, 6'd41);
      issue(2'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 6'd42);
      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 6'd43);
      expect_out(1'b1, 1'b1, 32'h1, 6'd40, 4'd4, 1'b0);
      expect_out(1'b1, 1'b1, 32'h1, 6'd40, 4'd4, 1'b0);
      expect_out(1'b1, 1'b1, 32'h1, 6'd40, 4'd4, 1'b0);
      bus.out_ready = 1'b1;
      repeat (4) @(posedge clock);
      #1 expect_out(1'b0, 1'b0, 32'h0, 6'd0, 4'd0, 1'b1);

      issue(2'd0, 32'd5, 32'd6, 6'd50);
      issue(2'd1, 32'd9, 32'd9, 6'd51);
      bus.in_valid = 1'b1;
      bus.in_dest_tag = 6'd52;
      flush = 1'b1;
      @(posedge clock);
      #1 bus.in_valid = 1'b0;
      flush = 1'b0;
      expect_out(1'b0, 1'b0, 32'h0, 6'd0, 4'd0, 1'b1);
      repeat (6) expect_out(1'b0, 1'b0, 32'h0, 6'd0, 4'd0, 1'b1);

      issue(2'd0, 32'd11, 32'd12, 6'd60);
      issue(2'd3, 32'd13, 32'd14, 6'd61);
      issue(2'd2, 32'd15, 32'd16, 6'd62);
      #3 reset = 1'b0;
      expect_out(1'b0, 1'b1, 32'h0, 6'd0, 4'd0, 1'b1);
      @(posedge clock);
      #1 reset = 1'b1;
      issue(2'd0, 32'd2, 32'd3, 6'd7);
      repeat (3) @(posedge clock);
      #1 expect_out(1'b1, 1'b1, 32'd6, 6'd7, 4'd1, 1'b1);

      @(posedge clock);
      #1;
      for (int cyc = 0; cyc < 20000 && acc_cnt < 1000; cyc++) begin
         bus.in_valid    = ($urandom_range(0, 3) != 0);
         bus.in_func     = 2'($urandom_range(0, 3));
         bus.in_rs1      = rnd_op();
         bus.in_rs2      = rnd_op();
         bus.in_dest_tag = 6'($urandom_range(0, 63));
         bus.out_ready   = ($urandom_range(0, 9) < 7);
         flush           = ($urandom_range(0, 49) == 0);
         @(negedge clock);
         if (bus.in_valid && !flush && !(m_pipe[NS-1].vld && !bus.out_ready)) acc_cnt++;
         @(posedge clock);
         #1;
      end
      bus.in_valid  = 1'b0;
      flush         = 1'b0;
      bus.out_ready = 1'b1;
      gen_act = acc_cnt;
      gen_exp = 1000;
      gen_en  = 1'b1;
      repeat (8) @(posedge clock);
      gen_en = 1'b0;
      #1 expect_out(1'b0, 1'b0, 32'h0, 6'd0, 4'd0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
